// File: rtl/single_cycle_top.sv
// Single-cycle RV32I-subset core: PC, instruction/data memories, register file,
// decoder and ALU all resolve combinationally and commit on one rising edge.
module single_cycle_top (
    input logic clk,
    input logic rst
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    logic [31:0] imem [0:1023] = '{default: 32'd0};
    logic [31:0] dmem [0:1023] = '{default: 32'd0};
    logic [31:0] rf   [0:31];

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [31:0] wb_data;
    logic        zero;
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    alu_op_t     alu_op;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input alu_op_t op);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            ALU_SUB: alu_f = a - b;
            ALU_AND: alu_f = a & b;
            ALU_OR:  alu_f = a | b;
            ALU_SLT: alu_f = (sa < sb) ? 32'd1 : 32'd0;
            default: alu_f = a + b;
        endcase
    endfunction

    assign inst     = imem[pc[11:2]];
    assign opcode   = inst[6:0];
    assign rd       = inst[11:7];
    assign funct3   = inst[14:12];
    assign rs1      = inst[19:15];
    assign rs2      = inst[24:20];
    assign funct7b5 = inst[30];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

    // Anything not recognised leaves every write enable low and falls through to PC+4.
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        alu_op     = ALU_ADD;
        alu_b      = rs2_val;
        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                case (funct3)
                    3'b000:  alu_op = funct7b5 ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b010:  alu_op = ALU_SLT;
                    default: reg_write = 1'b0;
                endcase
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_b     = imm_i;
                case (funct3)
                    3'b000:  alu_op = ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b010:  alu_op = ALU_SLT;
                    default: reg_write = 1'b0;
                endcase
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                alu_b      = imm_i;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_b     = imm_s;
            end
            OP_BEQ: begin
                branch = 1'b1;
                alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    assign alu_result = alu_f(rs1_val, alu_b, alu_op);
    assign zero       = (alu_result == 32'd0);
    assign wb_data    = mem_to_reg ? dmem[alu_result[11:2]] : alu_result;
    assign pc_next    = (branch && zero) ? (pc + imm_b) : (pc + 32'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'd0;
            end
        end else begin
            pc <= pc_next;
            if (reg_write && (rd != 5'd0)) begin
                rf[rd] <= wb_data;
            end
        end
    end

    // Data memory keeps its contents across reset; stores are held off while reset is high.
    always_ff @(posedge clk) begin
        if (mem_write && !rst) begin
            dmem[alu_result[11:2]] <= rs2_val;
        end
    end
endmodule

// File: tb/tb_single_cycle_top.sv
// Bench for single_cycle_top: directed programs plus random programs checked
// against an instruction-level model of the ISA subset.
module tb_single_cycle_top;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    single_cycle_top dut (
        .clk(clk),
        .rst(rst)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] prog  [0:1023];
    logic [31:0] m_reg [0:31];
    logic [31:0] m_mem [0:1023];
    logic [31:0] m_pc;

    localparam logic [31:0] NOP = 32'h00000013;

    function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] rand_inst();
        int k, rd, rs1, rs2, imm, f3, off;
        int f3s[4];
        logic [31:0] t;
        f3s = '{0, 7, 6, 2};
        k   = int'($urandom_range(0, 9));
        rd  = int'($urandom_range(0, 7));
        rs1 = int'($urandom_range(0, 7));
        rs2 = int'($urandom_range(0, 7));
        imm = int'($urandom_range(0, 4095)) - 2048;
        f3  = f3s[$urandom_range(0, 3)];
        case (k)
            0, 1: return r_t((f3 == 0 && $urandom_range(0, 1) == 1) ? 32 : 0, rs2, rs1, f3, rd);
            2, 3: return i_t(imm, rs1, f3, rd, 7'b0010011);
            4:    return i_t(imm, rs1, 2, rd, 7'b0000011);
            5:    return s_t(imm, rs2, rs1);
            6: begin
                off = int'($urandom_range(1, 4)) * 4;
                if ($urandom_range(0, 1) == 1) off = -off;
                return b_t(off, rs2, rs1);
            end
            7: begin
                t = $urandom();
                t[6:0] = 7'b0110111;
                return t;
            end
            default: return i_t(imm, rs1, 0, rd, 7'b0010011);
        endcase
    endfunction

    // Executes one instruction on the architectural model.
    task automatic model_step();
        logic [31:0] inst, a, b, val, addr, nxt;
        logic wr;
        int imm_i, imm_s, imm_b, idx;
        idx   = int'((m_pc >> 2) % 32'd1024);
        inst  = prog[idx];
        a     = m_reg[inst[19:15]];
        b     = m_reg[inst[24:20]];
        imm_i = $signed(inst[31:20]);
        imm_s = $signed({inst[31:25], inst[11:7]});
        imm_b = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
        nxt   = m_pc + 32'd4;
        wr    = 1'b0;
        val   = 32'd0;
        case (inst[6:0])
            7'b0110011: begin
                wr = 1'b1;
                case (inst[14:12])
                    3'd0:    val = inst[30] ? a - b : a + b;
                    3'd7:    val = a & b;
                    3'd6:    val = a | b;
                    3'd2:    val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
            end
            7'b0010011: begin
                wr = 1'b1;
                case (inst[14:12])
                    3'd0:    val = a + imm_i;
                    3'd7:    val = a & imm_i;
                    3'd6:    val = a | imm_i;
                    3'd2:    val = ($signed(a) < imm_i) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
            end
            7'b0000011: begin
                addr = a + imm_i;
                val  = m_mem[int'((addr >> 2) % 32'd1024)];
                wr   = 1'b1;
            end
            7'b0100011: begin
                addr = a + imm_s;
                m_mem[int'((addr >> 2) % 32'd1024)] = b;
            end
            7'b1100011: begin
                if (a == b) nxt = m_pc + imm_b;
            end
            default: ;
        endcase
        if (wr && inst[11:7] != 5'd0) m_reg[inst[11:7]] = val;
        m_pc = nxt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_nops();
        for (int i = 0; i < 1024; i++) prog[i] = NOP;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 1024; i++) dut.imem[i] = prog[i];
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst  = 1'b1;
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    endtask

    task automatic leave_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic alu_prog();
        fill_nops();
        prog[0] = i_t(5, 0, 0, 1, 7'b0010011);
        prog[1] = i_t(-3, 0, 0, 2, 7'b0010011);
        prog[2] = r_t(0, 2, 1, 0, 3);
        prog[3] = r_t(32, 2, 1, 0, 4);
        prog[4] = r_t(0, 1, 2, 2, 5);
        load_prog();
    endtask

    task automatic test_reset();
        int bad;
        enter_reset();
        alu_prog();
        leave_reset();
        compared++;
        if (dut.pc !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_pc_initial: got %h want 00000000", dut.pc);
        end
        for (int c = 0; c < 5; c++) tick();
        // Asynchronous assertion in the middle of a clock period.
        #2;
        rst  = 1'b1;
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        #1;
        compared++;
        if (dut.pc !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_pc_async: got %h want 00000000", dut.pc);
        end
        bad = 0;
        for (int i = 1; i < 32; i++) if (dut.rf[i] !== 32'd0) bad++;
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL reset_regs_async: %0d nonzero registers, want 0", bad);
        end
        @(posedge clk);
        #1;
        compared++;
        if (dut.pc !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_pc_held: got %h want 00000000", dut.pc);
        end
        leave_reset();
        for (int c = 1; c <= 2; c++) begin
            tick();
            compared++;
            if (dut.pc !== 32'(c * 4)) begin
                mismatched++;
                $display("FAIL reset_pc_seq%0d: got %h want %h", c, dut.pc, 32'(c * 4));
            end
        end
    endtask

    task automatic test_alu();
        logic [31:0] want [1:5];
        want = '{32'd5, 32'hFFFFFFFD, 32'd2, 32'd8, 32'd1};
        enter_reset();
        alu_prog();
        leave_reset();
        for (int c = 0; c < 5; c++) tick();
        for (int r = 1; r <= 5; r++) begin
            compared++;
            if (dut.rf[r] !== want[r]) begin
                mismatched++;
                $display("FAIL alu_x%0d: got %h want %h", r, dut.rf[r], want[r]);
            end
        end
    endtask

    task automatic test_memory();
        enter_reset();
        fill_nops();
        prog[0] = i_t(32'h64, 0, 0, 1, 7'b0010011);
        prog[1] = s_t(8, 1, 0);
        prog[2] = i_t(8, 0, 2, 6, 7'b0000011);
        prog[3] = i_t(9, 0, 2, 7, 7'b0000011);
        load_prog();
        leave_reset();
        for (int c = 0; c < 4; c++) tick();
        compared++;
        if (dut.dmem[2] !== 32'h64) begin
            mismatched++;
            $display("FAIL mem_word2: got %h want 00000064", dut.dmem[2]);
        end
        compared++;
        if (dut.rf[6] !== 32'h64) begin
            mismatched++;
            $display("FAIL mem_lw_x6: got %h want 00000064", dut.rf[6]);
        end
        compared++;
        if (dut.rf[7] !== 32'h64) begin
            mismatched++;
            $display("FAIL mem_lw_unaligned_x7: got %h want 00000064", dut.rf[7]);
        end
    endtask

    task automatic test_x0();
        enter_reset();
        fill_nops();
        prog[0] = i_t(9, 0, 0, 7, 7'b0010011);
        prog[1] = i_t(7, 0, 0, 0, 7'b0010011);
        prog[2] = r_t(0, 0, 0, 0, 7);
        load_prog();
        leave_reset();
        tick();
        compared++;
        if (dut.rf[7] !== 32'd9) begin
            mismatched++;
            $display("FAIL x0_setup_x7: got %h want 00000009", dut.rf[7]);
        end
        tick();
        tick();
        compared++;
        if (dut.rf[0] !== 32'd0) begin
            mismatched++;
            $display("FAIL x0_storage: got %h want 00000000", dut.rf[0]);
        end
        compared++;
        if (dut.rf[7] !== 32'd0) begin
            mismatched++;
            $display("FAIL x0_read_x7: got %h want 00000000", dut.rf[7]);
        end
    endtask

    task automatic test_branch();
        logic [31:0] want;
        for (int mode = 0; mode < 3; mode++) begin
            enter_reset();
            fill_nops();
            prog[0] = i_t(3, 0, 0, 1, 7'b0010011);
            if (mode == 0) prog[4] = b_t(8, 1, 1);
            else if (mode == 1) prog[4] = b_t(8, 0, 1);
            else prog[4] = b_t(-4, 0, 0);
            load_prog();
            leave_reset();
            for (int c = 0; c < 4; c++) tick();
            compared++;
            if (dut.pc !== 32'h10) begin
                mismatched++;
                $display("FAIL branch%0d_reach: got %h want 00000010", mode, dut.pc);
            end
            for (int c = 0; c < 4; c++) begin
                tick();
                if (mode == 0) want = 32'h18 + 32'(c * 4);
                else if (mode == 1) want = 32'h14 + 32'(c * 4);
                else want = (c % 2 == 0) ? 32'h0C : 32'h10;
                compared++;
                if (dut.pc !== want) begin
                    mismatched++;
                    $display("FAIL branch%0d_pc%0d: got %h want %h", mode, c, dut.pc, want);
                end
            end
        end
    endtask

    task automatic test_random();
        int bad;
        for (int p = 0; p < 4; p++) begin
            enter_reset();
            for (int i = 0; i < 1024; i++) prog[i] = rand_inst();
            load_prog();
            leave_reset();
            for (int c = 0; c < 150; c++) begin
                tick();
                compared++;
                if (dut.pc !== m_pc) begin
                    mismatched++;
                    $display("FAIL rand%0d_pc_c%0d: got %h want %h", p, c, dut.pc, m_pc);
                end
                for (int r = 1; r < 32; r++) begin
                    compared++;
                    if (dut.rf[r] !== m_reg[r]) begin
                        mismatched++;
                        $display("FAIL rand%0d_x%0d_c%0d: got %h want %h", p, r, c, dut.rf[r], m_reg[r]);
                    end
                end
            end
            bad = 0;
            for (int i = 0; i < 1024; i++) if (dut.dmem[i] !== m_mem[i]) bad++;
            compared++;
            if (bad != 0) begin
                mismatched++;
                $display("FAIL rand%0d_dmem: %0d words differ, want 0", p, bad);
            end
        end
    endtask

    task automatic test_midrun_reset();
        logic [31:0] snap [0:31];
        logic [31:0] snap_pc;
        int bad;
        enter_reset();
        fill_nops();
        prog[0] = i_t(32'h55, 0, 0, 1, 7'b0010011);
        prog[1] = s_t(12, 1, 0);
        prog[2] = i_t(12, 0, 2, 2, 7'b0000011);
        prog[3] = r_t(0, 1, 2, 0, 3);
        prog[4] = i_t(-1, 0, 0, 4, 7'b0010011);
        prog[5] = r_t(0, 3, 4, 2, 5);
        load_prog();
        leave_reset();
        for (int c = 0; c < 10; c++) tick();
        for (int r = 0; r < 32; r++) snap[r] = m_reg[r];
        snap_pc = m_pc;
        #3;
        rst  = 1'b1;
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        #1;
        bad = 0;
        for (int i = 1; i < 32; i++) if (dut.rf[i] !== 32'd0) bad++;
        compared++;
        if (dut.pc !== 32'd0 || bad != 0) begin
            mismatched++;
            $display("FAIL midreset_clear: pc %h with %0d nonzero regs, want pc 0 and 0 regs", dut.pc, bad);
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (dut.dmem[i] !== m_mem[i]) bad++;
        compared++;
        if (bad != 0 || dut.dmem[3] !== 32'h55) begin
            mismatched++;
            $display("FAIL midreset_dmem_kept: %0d words differ, word3 %h want 00000055", bad, dut.dmem[3]);
        end
        leave_reset();
        for (int c = 0; c < 10; c++) tick();
        compared++;
        if (dut.pc !== snap_pc) begin
            mismatched++;
            $display("FAIL midreset_rerun_pc: got %h want %h", dut.pc, snap_pc);
        end
        for (int r = 1; r < 6; r++) begin
            compared++;
            if (dut.rf[r] !== snap[r]) begin
                mismatched++;
                $display("FAIL midreset_rerun_x%0d: got %h want %h", r, dut.rf[r], snap[r]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_pc = 32'd0;
        #2;
        test_reset();
        test_alu();
        test_memory();
        test_x0();
        test_branch();
        test_midrun_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
